// File: rtl/usb_pkg.sv
// usb_pkg: shared USB line-level definitions: line states, sync pattern, bit-stuff limit.
package usb_pkg;
    localparam int USB_STUFF_BITS_N = 6;
    typedef enum logic [1:0] {LINE_J, LINE_K, LINE_SE0} line_t;
    // Bit i set means symbol i of the sync field is K (KJKJKJKK, symbol 0 first).
    localparam logic [7:0] USB_SYNC_PATTERN = 8'hD5;
    function automatic logic [1:0] line_levels(input line_t s, input logic ls);
        return s == LINE_SE0 ? 2'b00 : {(s == LINE_J) ^ ls, (s == LINE_K) ^ ls};
    endfunction
endpackage

// File: rtl/usb_bit_tick.sv
// usb_bit_tick: end-of-bit strobe every CLK_PER_BIT cycles, held at phase 0 while clr is high.
module usb_bit_tick #(
    parameter int CLK_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    logic [7:0] cnt;
    assign tick = cnt == 8'(CLK_PER_BIT - 1);
    always_ff @(posedge clk)
        cnt <= (rst || clr || tick) ? 8'd0 : cnt + 8'd1;
endmodule

// File: rtl/usb_line_tx.sv
// usb_line_tx: USB FS/LS packet transmitter: SYNC, NRZI with bit stuffing, EOP and inter-packet gap.
module usb_line_tx
    import usb_pkg::*;
#(
    parameter int CLK_PER_BIT  = 4,
    parameter int EOP_SE0_BITS = 2,
    parameter int IPD_BITS     = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       low_speed,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       dp_tx,
    output logic       dn_tx,
    output logic       tx_oe,
    output logic       busy,
    output logic       tx_err
);
    typedef enum logic [2:0] {IDLE, SYNC, DATA, STUFF, EOP_SE0, EOP_J, IPD} state_t;

    localparam logic [3:0] SE0_LAST = 4'(EOP_SE0_BITS - 1);
    localparam logic [3:0] IPD_LAST = 4'(IPD_BITS == 0 ? 0 : IPD_BITS - 1);

    state_t     state, state_n;
    logic [3:0] bcnt, bcnt_n;
    logic [2:0] ones, ones_n, ones_inc;
    logic [7:0] byte_q, byte_n;
    logic       prev_k, prev_k_n, last_q, last_n, ls_q, ls_n;
    logic       tick, cur_bit, cur_k, byte_end, take;
    line_t      sym;

    usb_bit_tick #(.CLK_PER_BIT(CLK_PER_BIT)) u_tick (
        .clk (clk),
        .rst (rst),
        .clr (state == IDLE),
        .tick(tick)
    );

    always_comb begin
        cur_bit  = byte_q[bcnt[2:0]];
        ones_inc = cur_bit ? ones + 3'd1 : 3'd0;
        // A byte ends after bit 7, or after the stuff bit that follows bit 7.
        byte_end = tick && bcnt == 4'd7 &&
                   (state == STUFF || (state == DATA && ones_inc != 3'(USB_STUFF_BITS_N)));
        take     = byte_end && !last_q && tx_valid;
        tx_ready = state == IDLE || (byte_end && !last_q);
        tx_err   = byte_end && !last_q && !tx_valid;
        cur_k    = state == STUFF ? !prev_k : (cur_bit ? prev_k : !prev_k);
        sym      = state == SYNC ? (USB_SYNC_PATTERN[bcnt[2:0]] ? LINE_K : LINE_J) :
                   (state == DATA || state == STUFF) ? (cur_k ? LINE_K : LINE_J) :
                   state == EOP_SE0 ? LINE_SE0 : LINE_J;
        {dp_tx, dn_tx} = line_levels(sym, ls_q);
        tx_oe    = state != IDLE && state != IPD;
        busy     = state != IDLE;
    end

    always_comb begin
        state_n  = state;
        bcnt_n   = bcnt;
        ones_n   = ones;
        prev_k_n = prev_k;
        byte_n   = byte_q;
        last_n   = last_q;
        ls_n     = ls_q;
        case (state)
            IDLE: if (tx_valid) begin
                state_n = SYNC;
                byte_n  = tx_data;
                last_n  = tx_last;
                ls_n    = low_speed;
                bcnt_n  = 4'd0;
            end
            SYNC: if (tick) begin
                bcnt_n = bcnt + 4'd1;
                if (bcnt == 4'd7) begin
                    state_n  = DATA;
                    bcnt_n   = 4'd0;
                    prev_k_n = 1'b1;
                    ones_n   = 3'd1;
                end
            end
            DATA: if (tick) begin
                prev_k_n = cur_k;
                ones_n   = ones_inc;
                if (ones_inc == 3'(USB_STUFF_BITS_N)) state_n = STUFF;
                else bcnt_n = bcnt + 4'd1;
            end
            STUFF: if (tick) begin
                prev_k_n = cur_k;
                ones_n   = 3'd0;
                bcnt_n   = bcnt + 4'd1;
                state_n  = DATA;
            end
            EOP_SE0: if (tick) begin
                bcnt_n = bcnt + 4'd1;
                if (bcnt == SE0_LAST) begin
                    state_n = EOP_J;
                    bcnt_n  = 4'd0;
                end
            end
            EOP_J: if (tick) begin
                state_n = IPD_BITS == 0 ? IDLE : IPD;
                bcnt_n  = 4'd0;
            end
            IPD: if (tick) begin
                bcnt_n = bcnt + 4'd1;
                if (bcnt == IPD_LAST) begin
                    state_n = IDLE;
                    bcnt_n  = 4'd0;
                end
            end
            default: state_n = IDLE;
        endcase
        // Byte boundary: chain the next byte with no gap, or close the packet.
        if (byte_end) begin
            bcnt_n  = 4'd0;
            state_n = take ? DATA : EOP_SE0;
            byte_n  = take ? tx_data : byte_q;
            last_n  = take ? tx_last : last_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            bcnt   <= 4'd0;
            ones   <= 3'd0;
            prev_k <= 1'b0;
            byte_q <= 8'd0;
            last_q <= 1'b0;
            ls_q   <= 1'b0;
        end else begin
            state  <= state_n;
            bcnt   <= bcnt_n;
            ones   <= ones_n;
            prev_k <= prev_k_n;
            byte_q <= byte_n;
            last_q <= last_n;
            ls_q   <= ls_n;
        end
    end
endmodule

// File: tb/tb_usb_line_tx.sv
// tb_usb_line_tx: table-driven packet vectors decoded from the line, plus reset sequences.
module tb_usb_line_tx;
    logic       clk = 0, rst = 1, low_speed = 0, tx_valid = 0, tx_last = 0, sel = 0;
    logic [7:0] tx_data = 0;
    logic a_ready, a_dp, a_dn, a_oe, a_busy, a_err;
    logic b_ready, b_dp, b_dn, b_oe, b_busy, b_err;
    logic rdy, dp, dn, oe, bsy, err;
    int   n_vec = 0, n_bad = 0;

    always #5 clk = ~clk;

    usb_line_tx u_a (
        .clk(clk), .rst(rst), .low_speed(low_speed), .tx_data(tx_data),
        .tx_valid(tx_valid && !sel), .tx_last(tx_last), .tx_ready(a_ready),
        .dp_tx(a_dp), .dn_tx(a_dn), .tx_oe(a_oe), .busy(a_busy), .tx_err(a_err)
    );
    usb_line_tx #(.CLK_PER_BIT(8), .IPD_BITS(0)) u_b (
        .clk(clk), .rst(rst), .low_speed(low_speed), .tx_data(tx_data),
        .tx_valid(tx_valid && sel), .tx_last(tx_last), .tx_ready(b_ready),
        .dp_tx(b_dp), .dn_tx(b_dn), .tx_oe(b_oe), .busy(b_busy), .tx_err(b_err)
    );

    assign rdy = sel ? b_ready : a_ready;
    assign dp  = sel ? b_dp : a_dp;
    assign dn  = sel ? b_dn : a_dn;
    assign oe  = sel ? b_oe : a_oe;
    assign bsy = sel ? b_busy : a_busy;
    assign err = sel ? b_err : a_err;

    typedef struct {
        logic [23:0] bytes;
        int n; bit ls; bit drop; bit sel;
        int e_oe; int e_busy; int e_stuff; int e_err; int e_rdy; int e_nb; bit e_after;
    } vec_t;

    vec_t tv[7];
    logic r_oe[1024], r_dp[1024], r_dn[1024], r_rdy[1024], r_bsy[1024], r_err[1024];

    task automatic chk(input string nm, input int v, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (vec %0d): got %0d expected %0d", nm, v, act, exp);
        end
    endtask

    // 0=J, 1=K, 2=SE0, 3=illegal
    function automatic int sym_of(input logic p, input logic n, input bit ls);
        if ({p, n} == 2'b00) return 2;
        if ({p, n} == (ls ? 2'b01 : 2'b10)) return 0;
        if ({p, n} == (ls ? 2'b10 : 2'b01)) return 1;
        return 3;
    endfunction

    task automatic run_vec(input int vi, input vec_t v);
        int last = -1, idx = 0, s = -1, oe_n = 0, busy_n = 0, err_n = 0, rdy_n = 0;
        int cpb, nb, k, prev, ones, nbits, stuffs, se0, hold_bad, sync_bad;
        int syms[64];
        int exp_sync[8] = '{1, 0, 1, 0, 1, 0, 1, 1};
        logic [7:0] acc, dec[3];
        bit hs = 0, b;
        cpb = v.sel ? 8 : 4;
        sel = v.sel;
        low_speed = v.ls;
        for (int c = 0; c < 1024; c++) begin
            @(negedge clk);
            if (c == 0) begin
                tx_data = v.bytes[7:0]; tx_last = (v.n == 1); tx_valid = 1;
            end else if (hs) begin
                idx++;
                if (idx < v.n && !v.drop) begin
                    tx_data = v.bytes[8*idx +: 8]; tx_last = (idx == v.n - 1);
                end else tx_valid = 0;
            end
            #1;
            r_oe[c] = oe; r_dp[c] = dp; r_dn[c] = dn; r_rdy[c] = rdy; r_bsy[c] = bsy; r_err[c] = err;
            hs = rdy && tx_valid;
            if (c > 0 && !bsy) begin last = c; break; end
        end
        tx_valid = 0;
        low_speed = 0;
        if (last < 0) begin
            chk("timeout", vi, 0, 1);
            return;
        end
        for (int c = 0; c <= last; c++) begin
            if (r_oe[c] && s < 0) s = c;
            oe_n += int'(r_oe[c]); busy_n += int'(r_bsy[c]); err_n += int'(r_err[c]);
            rdy_n += int'(r_rdy[c] && r_bsy[c]);
        end
        chk("oe_start", vi, s, 1);
        chk("oe_cycles", vi, oe_n, v.e_oe);
        chk("busy_cycles", vi, busy_n, v.e_busy);
        chk("err_pulses", vi, err_n, v.e_err);
        chk("ready_in_pkt", vi, rdy_n, v.e_rdy);
        if (s < 0) return;
        chk("ready_after_oe", vi, int'(r_rdy[s + oe_n]), int'(v.e_after));
        chk("idle_line", vi, int'({r_dp[last], r_dn[last]}), v.ls ? 1 : 2);
        chk("sync_first_raw", vi, int'({r_dp[s], r_dn[s]}), v.ls ? 2 : 1);
        nb = oe_n / cpb;
        hold_bad = 0;
        for (int i = 0; i < nb && i < 64; i++) begin
            syms[i] = sym_of(r_dp[s + i*cpb], r_dn[s + i*cpb], v.ls);
            for (int j = 1; j < cpb; j++)
                if ({r_dp[s + i*cpb + j], r_dn[s + i*cpb + j]} != {r_dp[s + i*cpb], r_dn[s + i*cpb]})
                    hold_bad++;
        end
        chk("symbol_hold", vi, hold_bad, 0);
        sync_bad = 0;
        for (int i = 0; i < 8; i++) if (i >= nb || syms[i] != exp_sync[i]) sync_bad++;
        chk("sync_pattern", vi, sync_bad, 0);
        prev = 1; ones = 1; nbits = 0; stuffs = 0; acc = 0; k = 8;
        while (k < nb && syms[k] != 2) begin
            b = (syms[k] == prev);
            prev = syms[k];
            if (ones == 6) begin
                stuffs++; ones = 0;
            end else begin
                ones = b ? ones + 1 : 0;
                acc = {b, acc[7:1]};
                nbits++;
                if (nbits % 8 == 0 && nbits <= 24) dec[nbits/8 - 1] = acc;
            end
            k++;
        end
        se0 = 0;
        while (k < nb && syms[k] == 2) begin se0++; k++; end
        chk("stuff_bits", vi, stuffs, v.e_stuff);
        chk("data_bits", vi, nbits, 8 * v.e_nb);
        chk("se0_bits", vi, se0, 2);
        chk("eop_j_final", vi, int'(k == nb - 1 && syms[k] == 0), 1);
        for (int i = 0; i < v.e_nb && 8*(i+1) <= nbits; i++)
            chk("decoded_byte", vi, int'(dec[i]), int'(v.bytes[8*i +: 8]));
    endtask

    initial begin
        tv[0] = '{bytes:24'h0000FF, n:1, ls:0, drop:0, sel:0, e_oe:80,  e_busy:104, e_stuff:1, e_err:0, e_rdy:0, e_nb:1, e_after:0};
        tv[1] = '{bytes:24'h002D80, n:2, ls:0, drop:0, sel:0, e_oe:108, e_busy:132, e_stuff:0, e_err:0, e_rdy:1, e_nb:2, e_after:0};
        tv[2] = '{bytes:24'h000080, n:1, ls:1, drop:0, sel:0, e_oe:76,  e_busy:100, e_stuff:0, e_err:0, e_rdy:0, e_nb:1, e_after:0};
        tv[3] = '{bytes:24'h563412, n:3, ls:0, drop:1, sel:0, e_oe:76,  e_busy:100, e_stuff:0, e_err:1, e_rdy:1, e_nb:1, e_after:0};
        tv[4] = '{bytes:24'h00FFFF, n:2, ls:0, drop:0, sel:0, e_oe:116, e_busy:140, e_stuff:2, e_err:0, e_rdy:1, e_nb:2, e_after:0};
        tv[5] = '{bytes:24'h0000FC, n:1, ls:0, drop:0, sel:0, e_oe:80,  e_busy:104, e_stuff:1, e_err:0, e_rdy:0, e_nb:1, e_after:0};
        tv[6] = '{bytes:24'h000080, n:1, ls:0, drop:0, sel:1, e_oe:152, e_busy:152, e_stuff:0, e_err:0, e_rdy:0, e_nb:1, e_after:1};

        repeat (3) @(negedge clk);
        chk("rst_oe", -1, int'(a_oe), 0);
        chk("rst_ready", -1, int'(a_ready), 1);
        chk("rst_busy", -1, int'(a_busy), 0);
        chk("rst_err", -1, int'(a_err), 0);
        chk("rst_dp", -1, int'(a_dp), 1);
        chk("rst_dn", -1, int'(a_dn), 0);
        chk("rst_b_oe", -1, int'(b_oe), 0);
        rst = 0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(i, tv[i]);

        sel = 0;
        @(negedge clk);
        tx_data = 8'hA5; tx_last = 1; tx_valid = 1;
        @(negedge clk);
        tx_valid = 0;
        repeat (40) @(negedge clk);
        chk("mid_data_oe", -2, int'(a_oe), 1);
        rst = 1;
        @(posedge clk);
        #1;
        chk("rst_mid_oe", -2, int'(a_oe), 0);
        chk("rst_mid_busy", -2, int'(a_busy), 0);
        chk("rst_mid_ready", -2, int'(a_ready), 1);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        run_vec(7, tv[1]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
